// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: captures one layer's parallel neuron outputs into a local
// buffer and streams them word by word (neuron 0 first) into the next layer.
// Sticky flags report dropped captures (overrun) and inconsistent valids.
module layer_seq_ctrl #(
    parameter int nn         = 30,
    parameter int data_width = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [nn-1:0]            in_valid,
    input  logic [nn*data_width-1:0] in_data_flat,
    input  logic                     dn_ready,
    input  logic                     clr_err,
    output logic                     x_valid,
    output logic [data_width-1:0]    x_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun,
    output logic                     mismatch
);

    localparam int IW = (nn > 1) ? $clog2(nn) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(nn - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [data_width-1:0] buf_mem [nn];

    logic cap_evt;
    logic part_evt;
    logic xfer;
    logic last_xfer;
    logic load;

    // Decode input events and the handshake from registered state.
    always_comb begin
        cap_evt   = &in_valid;
        part_evt  = (|in_valid) & ~cap_evt;
        xfer      = (state == STREAM) & dn_ready;
        last_xfer = xfer & (idx == LAST_IDX);
        // A capture is accepted when idle, or exactly on the last-word
        // transfer so back-to-back frames stream without a bubble.
        load      = cap_evt & ((state == IDLE) | last_xfer);
    end

    // Sequencer state, buffer, frame pulse and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            mismatch   <= 1'b0;
            for (int j = 0; j < nn; j++) begin
                buf_mem[j] <= '0;
            end
        end else begin
            frame_done <= last_xfer;

            if (load) begin
                for (int j = 0; j < nn; j++) begin
                    buf_mem[j] <= in_data_flat[j*data_width +: data_width];
                end
            end

            case (state)
                IDLE: begin
                    if (cap_evt) begin
                        state <= STREAM;
                        idx   <= '0;
                    end
                end
                STREAM: begin
                    if (last_xfer) begin
                        idx   <= '0;
                        state <= cap_evt ? STREAM : IDLE;
                    end else if (xfer) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase

            // A new error event takes priority over a simultaneous clear.
            if ((state == STREAM) && cap_evt && !last_xfer) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end

            if (part_evt) begin
                mismatch <= 1'b1;
            end else if (clr_err) begin
                mismatch <= 1'b0;
            end
        end
    end

    // Stream outputs are decoded purely from registered state.
    always_comb begin
        x_valid = (state == STREAM);
        busy    = (state == STREAM);
        x_data  = x_valid ? buf_mem[idx] : '0;
    end

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Inter-layer sequencer for the NPU layer chain. It captures the parallel neuron outputs of one layer (the `nn`-wide `o_valid` vector and the flattened `nn*data_width` result bus) into a local buffer. It then streams them one word per cycle, neuron 0 first, into the serial `x_in`/`x_valid` input of the next layer. A downstream ready lets the consumer throttle the stream. Sticky error flags report a layer that produces a new result while the previous one is still streaming, or whose neurons disagree on valid timing.

## Interface
- `nn`, 30: number of neurons in the producing layer (words per frame); ≥ 2.
- `data_width`, 16: word width in bits.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input `nn`: per-neuron valid from the producing layer.
- `in_data_flat` input `nn*data_width`: neuron j result at bits `[j*data_width +: data_width]`.
- `dn_ready` input 1: next layer accepts a word this cycle.
- `clr_err` input 1: synchronous clear of `overrun` and `mismatch`.
- `x_valid` output 1: `x_data` holds a valid word.
- `x_data` output `data_width`: streamed word; 0 when `x_valid` is low.
- `busy` output 1: high while in STREAM.
- `frame_done` output 1: one-cycle pulse after the last word of a frame transfers.
- `overrun` output 1: sticky; a full capture arrived while a frame was streaming and was dropped.
- `mismatch` output 1: sticky; `in_valid` was partially set (some bits, not all).

## Operation
- Buffer: `nn` registers of `data_width`, plus index `idx` of `$clog2(nn)` bits.
- Capture event: `&in_valid` = 1. Partial event: `|in_valid` = 1 and `&in_valid` = 0.
- States are IDLE and STREAM.
- IDLE, on a capture event: load all `nn` words, set `idx`=0, go to STREAM.
- IDLE, on a partial event: set `mismatch`, capture nothing, stay in IDLE.
- STREAM: drive `x_valid`=1 and `x_data`=buf[`idx`].
- A transfer occurs when `x_valid` and `dn_ready` are both high.
- On a transfer with `idx` < `nn`-1: increment `idx`.
- On a transfer with `idx` = `nn`-1 (last word): set `frame_done` for the next cycle.
  - With a simultaneous capture event: reload the buffer, set `idx`=0, stay in STREAM (back-to-back frames, no bubble).
  - Otherwise: go to IDLE.
- A capture event in STREAM that is not on the last-word transfer: drop the data, set `overrun`, leave buffer and `idx` untouched.
- A partial event in any state sets `mismatch`. It never captures.
- `dn_ready` low in STREAM: hold `idx`, `x_data` and `x_valid` stable (no data change while stalled).
- `clr_err`: clears both sticky flags next cycle. If `clr_err` coincides with a new error event, the set wins.
- Data is not modified: no arithmetic, sign or width change between `in_data_flat` and `x_data`.

## Timing
- Reset values (asynchronous): state IDLE, `idx`=0, buffer all 0. All outputs 0: `x_valid`, `x_data`, `busy`, `frame_done`, `overrun`, `mismatch`.
- Reset mid-frame: the stream aborts immediately, no `frame_done`. The first frame after reset release must be a fresh capture.
- Capture latency: capture event sampled at edge N; `x_valid`=1 with word 0 from cycle N+1.
- With `dn_ready` held high, words 0..`nn`-1 appear in cycles N+1..N+`nn`.
  - `frame_done` pulses in cycle N+`nn`+1.
  - `busy` is high in cycles N+1..N+`nn`.
- Each low `dn_ready` cycle adds exactly one cycle to the frame.
- Back-to-back: a capture on the last-word edge puts word 0 of the new frame in the very next cycle. `frame_done` still pulses for the finished frame.
- `frame_done`, `busy`, `x_valid` and `x_data` are registered or decoded directly from registered state. There is no combinational path from `in_*` to outputs.

## Test plan
- Basic frame (`nn`=4, `data_width`=16), `dn_ready`=1:
  - Stimulus: `in_valid`=4'b1111 for one cycle with words 0x0011, 0x0022, 0x0033, 0x0044.
  - Required: `x_data` = 0x0011, 0x0022, 0x0033, 0x0044 on 4 consecutive cycles starting one cycle later; `frame_done` on the 5th cycle; `busy` then low.
- Stall: same frame, `dn_ready` low for 2 cycles while word 0x0022 is presented.
  - Required: 0x0022 held for 3 cycles; `frame_done` 2 cycles later than in the basic case.
- Overrun: second capture (0x0AAA…) while word 0x0033 is streaming.
  - Required: stream still outputs 0x0044 next; `overrun`=1 and stays 1 until `clr_err`.
- Back-to-back: second capture exactly on the 0x0044 transfer edge.
  - Required: next cycle shows word 0 of the second frame; one `frame_done` pulse; no IDLE cycle.
- Mismatch: `in_valid`=4'b0101.
  - Required: `mismatch`=1, no `x_valid`; a subsequent `clr_err` clears it.
- Reset mid-frame: assert `rst` after 2 words.
  - Required: all outputs 0 immediately; no `frame_done`; next full capture streams normally from word 0.
